// File: rtl/gate_tt_pkg.sv
// rtl/gate_tt_pkg.sv - shared types and truth-table constants for the gate truth-table checker
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  // Settle counter width covers the full 1..255 settle range
  localparam int CNT_W = 8;

  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_tt_settle_cnt.sv
// rtl/gate_tt_settle_cnt.sv - loadable down-counter with terminal-count flag for input settling
module gate_tt_settle_cnt
  import gate_tt_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Flags the last settle cycle so the FSM leaves DRIVE after exactly load_val cycles
  assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/nandg.sv
// rtl/nandg.sv - two-input NAND gate used as the reference gate under test
module nandg (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a & b);

endmodule

// File: rtl/gate_tt_checker.sv
// rtl/gate_tt_checker.sv - walks a 2-input gate through all vectors and checks its truth table
// Optional feature: GATE_TT_CHECKER_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expected_tt,
  input  logic       gate_y,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

  state_t     state;
  logic [3:0] tt_q;
  logic [1:0] idx;
  logic       settle_tc;
  logic       cnt_load;
  logic       cnt_dec;
  logic       mismatch;
  logic       stop_early;
  logic       last_vec;

  assign cnt_load = ((state == IDLE) && start) || (state == SAMPLE);
  assign cnt_dec  = (state == DRIVE);
  assign last_vec = (idx == 2'd3);

  // An unknown gate_y makes the equality unknown, which falls through as a mismatch
  always_comb begin
    mismatch = 1'b1;
    if (gate_y == tt_q[idx]) begin
      mismatch = 1'b0;
    end
  end

`ifdef GATE_TT_CHECKER_STOP_ON_FAIL_EN
  assign stop_early = mismatch;
`else
  assign stop_early = 1'b0;
`endif

  gate_tt_settle_cnt u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .tc       (settle_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tt_q      <= 4'b0000;
      idx       <= 2'd0;
      A         <= 1'b0;
      B         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'b0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tt_q      <= expected_tt;
            fail_mask <= 4'b0000;
            pass      <= 1'b0;
            idx       <= 2'd0;
            {A, B}    <= 2'b00;
            busy      <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_tc) begin
            state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            fail_mask[idx] <= 1'b1;
          end
          if (last_vec || stop_early) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx    <= idx + 2'd1;
            {A, B} <= idx + 2'd1;
            state  <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (fail_mask == 4'b0000);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb/tb_gate_tt_checker.sv - directed self-checking bench for gate_tt_checker with nandg attached
module tb_gate_tt_checker;
  import gate_tt_pkg::*;

`ifdef GATE_TT_CHECKER_STOP_ON_FAIL_EN
  localparam logic [3:0] AND_MASK = 4'b0001;
  localparam int         AND_DONE = 4;
`else
  localparam logic [3:0] AND_MASK = 4'b1111;
  localparam int         AND_DONE = 13;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       start_s;
  logic       tie_one;
  logic [3:0] expected_tt;

  logic       a_m, b_m, busy_m, done_m, pass_m, nand_y_m, gy_m;
  logic [3:0] fm_m;
  logic       a1, b1, busy1, done1, pass1, y1;
  logic [3:0] fm1;
  logic       a5, b5, busy5, done5, pass5, y5;
  logic [3:0] fm5;

  int checks = 0;
  int errors = 0;

  logic [1:0] ab_log [0:31];
  logic       busy_log [0:31];

  assign gy_m = tie_one ? 1'b1 : nand_y_m;

  nandg u_nand_m (.a(a_m), .b(b_m), .y(nand_y_m));
  nandg u_nand_1 (.a(a1), .b(b1), .y(y1));
  nandg u_nand_5 (.a(a5), .b(b5), .y(y5));

  gate_tt_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected_tt(expected_tt), .gate_y(gy_m),
    .A(a_m), .B(b_m), .busy(busy_m), .done(done_m), .pass(pass_m), .fail_mask(fm_m)
  );

  gate_tt_checker #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .expected_tt(TT_NAND), .gate_y(y1),
    .A(a1), .B(b1), .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fm1)
  );

  gate_tt_checker #(.SETTLE_CYCLES(5)) dut_s5 (
    .clk(clk), .rst_n(rst_n), .start(start_s), .expected_tt(TT_NAND), .gate_y(y5),
    .A(a5), .B(b5), .busy(busy5), .done(done5), .pass(pass5), .fail_mask(fm5)
  );

  // Cycle c is observed 1 time unit after the c-th edge following the start-accept edge
  task automatic run_main(input logic [3:0] tt, input logic [3:0] tt_after, input int extra_a,
                          input int extra_b, output int done_cyc, output int n_done);
    done_cyc = 0;
    n_done   = 0;
    @(negedge clk);
    expected_tt = tt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    expected_tt = tt_after;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      start = ((c + 1) == extra_a) || ((c + 1) == extra_b);
      ab_log[c]   = {a_m, b_m};
      busy_log[c] = busy_m;
      if (done_m) begin
        n_done++;
        if (done_cyc == 0) done_cyc = c;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    start_s = 1'b0;
    tie_one = 1'b0;
    expected_tt = TT_NAND;
    #3;
    checks++; if ({a_m, b_m} !== 2'b00) begin errors++; $display("FAIL reset_ab: got %b expected 00", {a_m, b_m}); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_m); end
    checks++; if (done_m !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_m); end
    checks++; if (pass_m !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass_m); end
    checks++; if (fm_m !== 4'b0000) begin errors++; $display("FAIL reset_fail_mask: got %b expected 0000", fm_m); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy_m); end
  endtask

  task automatic test_nand;
    int dc, nd;
    run_main(TT_NAND, TT_NAND, 0, 0, dc, nd);
    checks++; if (dc !== 13) begin errors++; $display("FAIL nand_done_cycle: got %0d expected 13", dc); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL nand_done_count: got %0d expected 1", nd); end
    checks++; if (pass_m !== 1'b1) begin errors++; $display("FAIL nand_pass: got %b expected 1", pass_m); end
    checks++; if (fm_m !== 4'b0000) begin errors++; $display("FAIL nand_fail_mask: got %b expected 0000", fm_m); end
    for (int c = 0; c < 12; c++) begin
      logic [1:0] exp_ab;
      exp_ab = 2'(c / 3);
      checks++; if (ab_log[c] !== exp_ab) begin errors++; $display("FAIL nand_walk_ab c=%0d: got %b expected %b", c, ab_log[c], exp_ab); end
      checks++; if (busy_log[c] !== 1'b1) begin errors++; $display("FAIL nand_busy c=%0d: got %b expected 1", c, busy_log[c]); end
    end
    checks++; if (busy_log[12] !== 1'b0) begin errors++; $display("FAIL nand_busy_done_state: got %b expected 0", busy_log[12]); end
    checks++; if (ab_log[20] !== 2'b11) begin errors++; $display("FAIL nand_ab_hold: got %b expected 11", ab_log[20]); end
  endtask

  task automatic test_and;
    int dc, nd;
    run_main(TT_AND, TT_NAND, 0, 0, dc, nd);
    checks++; if (dc !== AND_DONE) begin errors++; $display("FAIL and_done_cycle: got %0d expected %0d", dc, AND_DONE); end
    checks++; if (pass_m !== 1'b0) begin errors++; $display("FAIL and_pass: got %b expected 0", pass_m); end
    checks++; if (fm_m !== AND_MASK) begin errors++; $display("FAIL and_fail_mask: got %b expected %b", fm_m, AND_MASK); end
  endtask

  task automatic test_tie_one;
    int dc, nd;
    tie_one = 1'b1;
    run_main(TT_NAND, TT_NAND, 0, 0, dc, nd);
    tie_one = 1'b0;
    checks++; if (dc !== 13) begin errors++; $display("FAIL tie1_done_cycle: got %0d expected 13", dc); end
    checks++; if (pass_m !== 1'b0) begin errors++; $display("FAIL tie1_pass: got %b expected 0", pass_m); end
    checks++; if (fm_m !== 4'b1000) begin errors++; $display("FAIL tie1_fail_mask: got %b expected 1000", fm_m); end
  endtask

  task automatic test_back_to_back;
    int dc, nd, c;
    run_main(TT_NAND, TT_NAND, 3, 7, dc, nd);
    checks++; if (dc !== 13) begin errors++; $display("FAIL restart_ignored_cycle: got %0d expected 13", dc); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL restart_ignored_count: got %0d expected 1", nd); end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c = 0;
    while (!done_m && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    checks++; if (c !== 13) begin errors++; $display("FAIL b2b_first_done: got %0d expected 13", c); end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (pass_m !== 1'b0) begin errors++; $display("FAIL b2b_pass_cleared: got %b expected 0", pass_m); end
    c = 0;
    while (!done_m && c < 40) begin
      @(posedge clk);
      #1;
      c++;
    end
    checks++; if (c !== 13) begin errors++; $display("FAIL b2b_second_done: got %0d expected 13", c); end
    checks++; if (pass_m !== 1'b1) begin errors++; $display("FAIL b2b_second_pass: got %b expected 1", pass_m); end
  endtask

  task automatic test_reset_midrun;
    int dc, nd, dones;
    @(negedge clk);
    expected_tt = TT_NAND;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if ({a_m, b_m} !== 2'b10) begin errors++; $display("FAIL midrun_ab: got %b expected 10", {a_m, b_m}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({a_m, b_m} !== 2'b00) begin errors++; $display("FAIL midrun_reset_ab: got %b expected 00", {a_m, b_m}); end
    checks++; if (busy_m !== 1'b0) begin errors++; $display("FAIL midrun_reset_busy: got %b expected 0", busy_m); end
    checks++; if ({done_m, pass_m, fm_m} !== 6'd0) begin errors++; $display("FAIL midrun_reset_status: got %b expected 000000", {done_m, pass_m, fm_m}); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done_m || busy_m) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrun_no_done: got %0d active cycles expected 0", dones); end
    run_main(TT_NAND, TT_NAND, 0, 0, dc, nd);
    checks++; if (dc !== 13) begin errors++; $display("FAIL midrun_rerun_cycle: got %0d expected 13", dc); end
    checks++; if (pass_m !== 1'b1) begin errors++; $display("FAIL midrun_rerun_pass: got %b expected 1", pass_m); end
  endtask

  task automatic test_settle;
    int d1, d5, e1, e5;
    d1 = 0; d5 = 0; e1 = 0; e5 = 0;
    @(negedge clk);
    start_s = 1'b1;
    @(posedge clk);
    #1;
    start_s = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (c < 8 && {a1, b1} !== 2'(c / 2)) e1++;
      if (c < 24 && {a5, b5} !== 2'(c / 6)) e5++;
      if (done1 && d1 == 0) d1 = c;
      if (done5 && d5 == 0) d5 = c;
    end
    checks++; if (d1 !== 9) begin errors++; $display("FAIL settle1_done_cycle: got %0d expected 9", d1); end
    checks++; if (d5 !== 25) begin errors++; $display("FAIL settle5_done_cycle: got %0d expected 25", d5); end
    checks++; if (e1 !== 0) begin errors++; $display("FAIL settle1_hold: got %0d bad cycles expected 0", e1); end
    checks++; if (e5 !== 0) begin errors++; $display("FAIL settle5_hold: got %0d bad cycles expected 0", e5); end
    checks++; if ({pass1, pass5} !== 2'b11) begin errors++; $display("FAIL settle_pass: got %b expected 11", {pass1, pass5}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nand();
    test_and();
    test_tie_one();
    test_back_to_back();
    test_reset_midrun();
    test_settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
